calc_entry_ctrl: RTL and testbench

//  Sequencer for the two-function (add/sub) calculator. Consumes decoded keypad strobes
//  (value/valid from keypad_base) and builds two signed BCD operands plus an operator.

---
 rtl/calc_entry_ctrl_if.sv | 31 +++
 rtl/calc_entry_ctrl.sv | 251 +++++++++++++++++++++++++
 tb/tb_calc_entry_ctrl.sv | 236 +++++++++++++++++++++++
 3 files changed

// File: rtl/calc_entry_ctrl_if.sv
// calc_entry_ctrl_if
//   Bundles the keypad strobes, the ALU handshake and the operand/display
//   outputs of the calculator entry sequencer.
//   master : the sequencer (drives operands, alu_start, disp_sel, error)
//   slave  : its environment (keypad decoder, ALU, display path)
interface calc_entry_ctrl_if #(
  parameter int DIGITS = 3
);
  logic                  key_valid;
  logic [3:0]            key_value;
  logic                  alu_done;
  logic                  alu_ovf;
  logic [DIGITS*4-1:0]   operand_a;
  logic                  sign_a;
  logic [DIGITS*4-1:0]   operand_b;
  logic                  sign_b;
  logic                  op_sel;
  logic                  alu_start;
  logic [1:0]            disp_sel;
  logic                  error;

  modport master (
    input  key_valid, key_value, alu_done, alu_ovf,
    output operand_a, sign_a, operand_b, sign_b, op_sel, alu_start, disp_sel, error
  );

  modport slave (
    output key_valid, key_value, alu_done, alu_ovf,
    input  operand_a, sign_a, operand_b, sign_b, op_sel, alu_start, disp_sel, error
  );
endinterface

// File: rtl/calc_entry_ctrl.sv
// calc_entry_ctrl
//   Entry sequencer for the add/sub calculator. Turns keypad strobes into two
//   signed BCD operands and an operator, range-checks each operand, launches
//   the ALU with a start/done handshake and picks what the display shows.
// Ports
//   clk        system clock, rising edge
//   rst_n      asynchronous active-low reset
//   bus.key_valid / key_value   keypad strobe and code (rising edge = one key)
//   bus.alu_done / alu_ovf      ALU result ready / overflow (only seen in WAIT)
//   bus.operand_a/b, sign_a/b   BCD magnitudes (digit 0 in [3:0]) and signs
//   bus.op_sel                  0 = add, 1 = subtract
//   bus.alu_start               one-cycle ALU launch pulse
//   bus.disp_sel                0 A entry, 1 B entry, 2 result, 3 error
//   bus.error                   high in ERROR
//
// state     | meaning
// ----------+--------------------------------------------------
// ENTER_A   | collecting digits/sign of operand A
// ENTER_B   | operator chosen, collecting operand B
// START     | one-cycle alu_start pulse, arms the timeout
// WAIT      | waiting for alu_done or timeout
// RESULT    | ALU result on display, operands frozen
// ERROR     | range error, ALU overflow or timeout; only C leaves
module calc_entry_ctrl #(
  parameter int DIGITS  = 3,
  parameter int MAX_MAG = 127,
  parameter int TIMEOUT = 255
) (
  input  logic               clk,
  input  logic               rst_n,
  calc_entry_ctrl_if.master  bus
);

  localparam int OW = DIGITS * 4;
  localparam int CW = $clog2(DIGITS + 1);
  localparam int BW = $clog2(10 ** DIGITS);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [3:0] K_ADD = 4'hA;
  localparam logic [3:0] K_SUB = 4'hB;
  localparam logic [3:0] K_CLR = 4'hC;
  localparam logic [3:0] K_NEG = 4'hD;
  localparam logic [3:0] K_EQ  = 4'hE;
  localparam logic [3:0] K_BSP = 4'hF;

  typedef enum logic [2:0] {
    S_ENTER_A,
    S_ENTER_B,
    S_START,
    S_WAIT,
    S_RESULT,
    S_ERROR
  } state_t;

  state_t          state_q, state_d;
  logic            kv_q;
  logic            evt_q;
  logic [3:0]      key_q;
  logic [OW-1:0]   a_q, a_d, b_q, b_d;
  logic            sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [CW-1:0]   cnt_a_q, cnt_a_d, cnt_b_q, cnt_b_d;
  logic            op_q, op_d;
  logic [TW-1:0]   tmr_q, tmr_d;

  logic            is_digit;
  logic [OW-1:0]   act_mag;
  logic [BW-1:0]   act_bin;
  logic            too_big;

  // Keypad edge detect: the event and its code are registered, so a key is
  // acted on the cycle after the key_valid rising edge; a held key is one event.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      kv_q  <= 1'b0;
      evt_q <= 1'b0;
      key_q <= 4'h0;
    end else begin
      kv_q  <= bus.key_valid;
      evt_q <= bus.key_valid & ~kv_q;
      if (bus.key_valid & ~kv_q) key_q <= bus.key_value;
    end
  end

  assign is_digit = (key_q <= 4'd9);

  // Binary value of the operand being edited, for the magnitude check.
  always_comb begin
    act_mag = (state_q == S_ENTER_B) ? b_q : a_q;
    act_bin = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      act_bin = act_bin * BW'(10) + BW'(act_mag[i*4 +: 4]);
    end
  end

  assign too_big = (act_bin > BW'(MAX_MAG));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= S_ENTER_A;
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      cnt_a_q  <= '0;
      cnt_b_q  <= '0;
      op_q     <= 1'b0;
      tmr_q    <= '0;
    end else begin
      state_q  <= state_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      cnt_a_q  <= cnt_a_d;
      cnt_b_q  <= cnt_b_d;
      op_q     <= op_d;
      tmr_q    <= tmr_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    sign_a_d = sign_a_q;
    sign_b_d = sign_b_q;
    cnt_a_d  = cnt_a_q;
    cnt_b_d  = cnt_b_q;
    op_d     = op_q;
    tmr_d    = tmr_q;

    if (evt_q && key_q == K_CLR) begin
      a_d      = '0;
      b_d      = '0;
      sign_a_d = 1'b0;
      sign_b_d = 1'b0;
      cnt_a_d  = '0;
      cnt_b_d  = '0;
      op_d     = 1'b0;
      state_d  = S_ENTER_A;
    end else begin
      unique case (state_q)
        S_ENTER_A: begin
          if (evt_q) begin
            if (is_digit) begin
              if (cnt_a_q != CW'(DIGITS)) begin
                a_d     = {a_q[OW-5:0], key_q};
                cnt_a_d = cnt_a_q + CW'(1);
              end
            end else if (key_q == K_BSP) begin
              if (cnt_a_q != '0) begin
                a_d     = a_q >> 4;
                cnt_a_d = cnt_a_q - CW'(1);
              end
            end else if (key_q == K_NEG) begin
              sign_a_d = ~sign_a_q;
            end else if (key_q == K_ADD || key_q == K_SUB) begin
              if (too_big) begin
                state_d = S_ERROR;
              end else begin
                op_d     = key_q[0];
                b_d      = '0;
                sign_b_d = 1'b0;
                cnt_b_d  = '0;
                state_d  = S_ENTER_B;
              end
            end
          end
        end

        S_ENTER_B: begin
          if (evt_q) begin
            if (is_digit) begin
              if (cnt_b_q != CW'(DIGITS)) begin
                b_d     = {b_q[OW-5:0], key_q};
                cnt_b_d = cnt_b_q + CW'(1);
              end
            end else if (key_q == K_BSP) begin
              if (cnt_b_q != '0) begin
                b_d     = b_q >> 4;
                cnt_b_d = cnt_b_q - CW'(1);
              end
            end else if (key_q == K_NEG) begin
              sign_b_d = ~sign_b_q;
            end else if (key_q == K_ADD || key_q == K_SUB) begin
              // Operator can still be changed until B has a digit.
              if (cnt_b_q == '0) op_d = key_q[0];
            end else if (key_q == K_EQ) begin
              if (cnt_b_q != '0) state_d = too_big ? S_ERROR : S_START;
            end
          end
        end

        S_START: begin
          // Down-counter terminates at 1 so ERROR lands exactly TIMEOUT
          // cycles after the alu_start cycle.
          tmr_d   = TW'(TIMEOUT - 1);
          state_d = S_WAIT;
        end

        S_WAIT: begin
          if (bus.alu_done) begin
            state_d = bus.alu_ovf ? S_ERROR : S_RESULT;
          end else if (tmr_q == TW'(1)) begin
            state_d = S_ERROR;
          end else begin
            tmr_d = tmr_q - TW'(1);
          end
        end

        S_RESULT: begin
          if (evt_q && is_digit) begin
            a_d      = {{(OW-4){1'b0}}, key_q};
            b_d      = '0;
            sign_a_d = 1'b0;
            sign_b_d = 1'b0;
            cnt_a_d  = CW'(1);
            cnt_b_d  = '0;
            op_d     = 1'b0;
            state_d  = S_ENTER_A;
          end
        end

        S_ERROR: begin
        end

        default: state_d = S_ENTER_A;
      endcase
    end
  end

  assign bus.operand_a = a_q;
  assign bus.operand_b = b_q;
  assign bus.sign_a    = sign_a_q;
  assign bus.sign_b    = sign_b_q;
  assign bus.op_sel    = op_q;
  assign bus.alu_start = (state_q == S_START);
  assign bus.error     = (state_q == S_ERROR);

  always_comb begin
    bus.disp_sel = 2'd0;
    case (state_q)
      S_ENTER_A:                 bus.disp_sel = 2'd0;
      S_ENTER_B, S_START, S_WAIT: bus.disp_sel = 2'd1;
      S_RESULT:                  bus.disp_sel = 2'd2;
      S_ERROR:                   bus.disp_sel = 2'd3;
      default:                   bus.disp_sel = 2'd0;
    endcase
  end

endmodule

// File: tb/tb_calc_entry_ctrl.sv
module tb_calc_entry_ctrl;
  localparam int DIGITS = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  calc_entry_ctrl_if #(.DIGITS(DIGITS)) bus ();

  calc_entry_ctrl #(.DIGITS(DIGITS), .MAX_MAG(127), .TIMEOUT(255)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct {
    logic [3:0]  key;
    logic [11:0] a;
    logic [11:0] b;
    logic        sa;
    logic        sb;
    logic        op;
    logic [1:0]  disp;
    logic        err;
  } vec_t;

  vec_t vecs[$];
  int   total = 0;
  int   bad = 0;
  int   starts = 0;

  always @(negedge clk) if (bus.alu_start) starts++;

  function automatic logic [29:0] obs();
    return {bus.operand_a, bus.operand_b, bus.sign_a, bus.sign_b, bus.op_sel, bus.disp_sel, bus.error};
  endfunction

  function automatic logic [29:0] pack(input logic [11:0] a, input logic [11:0] b, input logic sa,
                                       input logic sb, input logic op, input logic [1:0] disp, input logic err);
    return {a, b, sa, sb, op, disp, err};
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Strobe a key; returns at the negedge where alu_start (if any) has not yet been sampled.
  task automatic press_nowait(input logic [3:0] k);
    bus.key_valid = 1'b1;
    bus.key_value = k;
    @(negedge clk);
    bus.key_valid = 1'b0;
  endtask

  // Strobe a key and return once its effect is visible.
  task automatic press(input logic [3:0] k);
    press_nowait(k);
    @(negedge clk);
  endtask

  task automatic wait_start(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus.alu_start) begin
        ok = 1'b1;
        break;
      end
    end
    check("alu_start_seen", 32'(ok), 32'd1);
  endtask

  initial begin
    bit ok;
    int n;
    int s0;

    bus.key_valid = 1'b0;
    bus.key_value = 4'h0;
    bus.alu_done  = 1'b0;
    bus.alu_ovf   = 1'b0;

    // key | a | b | sa | sb | op | disp | err  (state after the key)
    vecs.push_back('{4'h7, 12'h007, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hF, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hF, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h3, 12'h003, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hD, 12'h003, 12'h000, 1, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hD, 12'h003, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hE, 12'h003, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hC, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h4, 12'h004, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hD, 12'h004, 12'h000, 1, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hB, 12'h004, 12'h000, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'hA, 12'h004, 12'h000, 1, 0, 0, 2'd1, 0});
    vecs.push_back('{4'hB, 12'h004, 12'h000, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'hE, 12'h004, 12'h000, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'h9, 12'h004, 12'h009, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'hA, 12'h004, 12'h009, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'h9, 12'h004, 12'h099, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'h9, 12'h004, 12'h999, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'h9, 12'h004, 12'h999, 1, 0, 1, 2'd1, 0});
    vecs.push_back('{4'hD, 12'h004, 12'h999, 1, 1, 1, 2'd1, 0});
    vecs.push_back('{4'hE, 12'h004, 12'h999, 1, 1, 1, 2'd3, 1});
    vecs.push_back('{4'h5, 12'h004, 12'h999, 1, 1, 1, 2'd3, 1});
    vecs.push_back('{4'hC, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h1, 12'h001, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h2, 12'h012, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h8, 12'h128, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hA, 12'h128, 12'h000, 0, 0, 0, 2'd3, 1});
    vecs.push_back('{4'hC, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h1, 12'h001, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h2, 12'h012, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'h7, 12'h127, 12'h000, 0, 0, 0, 2'd0, 0});
    vecs.push_back('{4'hA, 12'h127, 12'h000, 0, 0, 0, 2'd1, 0});
    vecs.push_back('{4'hC, 12'h000, 12'h000, 0, 0, 0, 2'd0, 0});

    // Reset state
    repeat (3) @(negedge clk);
    check("reset_outputs", 32'(obs()), 32'd0);
    check("reset_alu_start", 32'(bus.alu_start), 32'd0);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    foreach (vecs[i]) begin
      press(vecs[i].key);
      check($sformatf("vec%0d_key%0h", i, vecs[i].key), 32'(obs()),
            32'(pack(vecs[i].a, vecs[i].b, vecs[i].sa, vecs[i].sb, vecs[i].op, vecs[i].disp, vecs[i].err)));
    end

    // 12 + 5 = with alu_done 3 cycles after the start pulse
    s0 = starts;
    press(4'h1); press(4'h2); press(4'hA); press(4'h5);
    press_nowait(4'hE);
    wait_start(ok);
    repeat (3) @(negedge clk);
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    repeat (3) @(negedge clk);
    check("add_result", 32'(obs()), 32'(pack(12'h012, 12'h005, 0, 0, 0, 2'd2, 0)));
    check("add_one_start", 32'(starts - s0), 32'd1);

    // RESULT: operator keys ignored, a digit starts a fresh A
    press(4'hA);
    check("result_op_ignored", 32'(obs()), 32'(pack(12'h012, 12'h005, 0, 0, 0, 2'd2, 0)));
    press(4'h3);
    check("result_digit", 32'(obs()), 32'(pack(12'h003, 12'h000, 0, 0, 0, 2'd0, 0)));

    // alu_done outside WAIT does nothing
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    @(negedge clk);
    check("stray_done_enter_a", 32'(obs()), 32'(pack(12'h003, 12'h000, 0, 0, 0, 2'd0, 0)));

    // ALU overflow goes to ERROR
    press(4'hB); press(4'h1);
    press_nowait(4'hE);
    wait_start(ok);
    @(negedge clk);
    bus.alu_done = 1'b1;
    bus.alu_ovf  = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    bus.alu_ovf  = 1'b0;
    check("ovf_error", 32'(obs()), 32'(pack(12'h003, 12'h001, 0, 0, 1, 2'd3, 1)));
    press(4'hC);

    // Timeout: ERROR exactly 255 cycles after the start pulse
    press(4'h1); press(4'hB); press(4'h1);
    press_nowait(4'hE);
    wait_start(ok);
    n = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      n++;
      if (bus.error) break;
    end
    check("timeout_cycles", 32'(n), 32'd255);
    check("timeout_disp", 32'(bus.disp_sel), 32'd3);
    press(4'hC);

    // C and alu_done in the same cycle: C wins
    press(4'h1); press(4'hA); press(4'h1);
    press_nowait(4'hE);
    wait_start(ok);
    @(negedge clk);
    bus.key_valid = 1'b1;
    bus.key_value = 4'hC;
    @(negedge clk);
    bus.key_valid = 1'b0;
    bus.alu_done  = 1'b1;
    @(negedge clk);
    bus.alu_done  = 1'b0;
    check("c_beats_done", 32'(obs()), 32'd0);
    repeat (3) @(negedge clk);
    bus.alu_done = 1'b1;
    @(negedge clk);
    bus.alu_done = 1'b0;
    repeat (2) @(negedge clk);
    check("late_done_ignored", 32'(obs()), 32'd0);

    // Held key gives one event
    bus.key_valid = 1'b1;
    bus.key_value = 4'h6;
    repeat (50) @(negedge clk);
    bus.key_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("held_key_single", 32'(bus.operand_a), 32'h006);
    press(4'h7);
    check("held_key_next", 32'(bus.operand_a), 32'h067);
    press(4'hC);

    // Asynchronous reset in WAIT
    press(4'h2); press(4'hA); press(4'h3);
    press_nowait(4'hE);
    wait_start(ok);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("async_reset_outputs", 32'(obs()), 32'd0);
    check("async_reset_start", 32'(bus.alu_start), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
